// File: rtl/au_sign_denorm_if.sv
// Request/result handshake bundle for the iterative sign-filling right shifter.
// The master side issues operands and accepts results; the slave side is the shifter.
interface au_sign_denorm_if #(
   parameter int WIDTH = 8,
   parameter int SW    = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [SW-1:0]    sh;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] z;
   logic             sticky;

   modport master (
      output in_valid, a, sh, out_ready,
      input  in_ready, out_valid, z, sticky
   );

   modport slave (
      input  in_valid, a, sh, out_ready,
      output in_ready, out_valid, z, sticky
   );
endinterface

// File: rtl/au_sign_denorm.sv
// Iterative arithmetic right shifter with sticky collection: one binary stage of the
// shift amount per cycle, sign-filled, fixed SW-cycle latency between handshakes.
module au_sign_denorm #(
   parameter int WIDTH = 8,
   parameter int SW    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   au_sign_denorm_if.slave      bus
);
   localparam int KW = (SW > 1) ? $clog2(SW) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                  r_state;
   logic signed [WIDTH-1:0] r_data;
   logic [SW-1:0]           r_cnt;
   logic [KW-1:0]           r_k;
   logic                    r_stk;
   logic                    r_in_ready;
   logic                    r_out_valid;

   logic                    w_bit;
   logic signed [WIDTH-1:0] w_data_nxt;
   logic                    w_stk_nxt;

   // A stage whose distance reaches the full word flushes everything to sign fill.
   function automatic logic big_stage(input int unsigned k);
      return (k >= 31) || ((32'd1 << k) >= unsigned'(WIDTH));
   endfunction

   function automatic logic signed [WIDTH-1:0] shift_stage(
      input logic signed [WIDTH-1:0] d,
      input int unsigned             k
   );
      if (big_stage(k)) return {WIDTH{d[WIDTH-1]}};
      return d >>> (32'd1 << k);
   endfunction

   function automatic logic shifted_out(
      input logic signed [WIDTH-1:0] d,
      input int unsigned             k
   );
      logic s;
      s = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (big_stage(k) || (unsigned'(i) < (32'd1 << k))) s = s | d[i];
      end
      return s;
   endfunction

   always_comb begin
      w_bit      = r_cnt[r_k];
      w_data_nxt = r_data;
      w_stk_nxt  = r_stk;
      if (w_bit) begin
         w_data_nxt = shift_stage(r_data, 32'(r_k));
         w_stk_nxt  = r_stk | shifted_out(r_data, 32'(r_k));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_data      <= '0;
         r_cnt       <= '0;
         r_k         <= '0;
         r_stk       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_data     <= bus.a;
                  r_cnt      <= bus.sh;
                  r_k        <= '0;
                  r_stk      <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_state    <= SHIFT;
               end
            end
            // Every stage runs regardless of its cnt bit, giving a fixed latency.
            SHIFT: begin
               r_data <= w_data_nxt;
               r_stk  <= w_stk_nxt;
               if (r_k == KW'(SW - 1)) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.z         = r_data;
   assign bus.sticky    = r_stk;
endmodule
